// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase controller.
// TRAFFIC_WALK_FLASH_EN adds the WALK_FLASH state to the enum.
package traffic_pkg;

    localparam int unsigned SEC_W  = 8;
    localparam int unsigned LAMP_W = 8;

    typedef enum logic [2:0] {
        ALL_RED_A  = 3'd0,
        A_GREEN    = 3'd1,
        A_YELLOW   = 3'd2,
        ALL_RED_B  = 3'd3,
        B_GREEN    = 3'd4,
        B_YELLOW   = 3'd5,
        WALK       = 3'd6
`ifdef TRAFFIC_WALK_FLASH_EN
        , WALK_FLASH = 3'd7
`endif
    } state_t;

    localparam int unsigned DEF_GREEN_A_S = 10;
    localparam int unsigned DEF_GREEN_B_S = 10;
    localparam int unsigned DEF_YELLOW_S  = 3;
    localparam int unsigned DEF_ALLRED_S  = 1;
    localparam int unsigned DEF_WALK_S    = 6;
    localparam int unsigned DEF_FLASH_S   = 4;

    // Bit positions inside the registered lamp vector
    localparam logic [2:0] LAMP_GA = 3'd0;
    localparam logic [2:0] LAMP_YA = 3'd1;
    localparam logic [2:0] LAMP_RA = 3'd2;
    localparam logic [2:0] LAMP_GB = 3'd3;
    localparam logic [2:0] LAMP_YB = 3'd4;
    localparam logic [2:0] LAMP_RB = 3'd5;
    localparam logic [2:0] LAMP_GW = 3'd6;
    localparam logic [2:0] LAMP_RW = 3'd7;

    localparam logic [LAMP_W-1:0] LAMP_ALL_RED = 8'hA4;

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Tick/request inputs and lamp outputs of the phase controller.
interface traffic_phase_ctrl_if;
    logic tick_1hz;
    logic tick_2hz;
    logic walk_req;
    logic Ga, Ya, Ra;
    logic Gb, Yb, Rb;
    logic Gw, Rw;

    modport master (
        output tick_1hz, tick_2hz, walk_req,
        input  Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw
    );

    modport slave (
        input  tick_1hz, tick_2hz, walk_req,
        output Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw
    );
endinterface

// File: rtl/walk_req_sync.sv
// Two-flop synchronizer for the pedestrian button plus a rising-edge detector.
module walk_req_sync (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic rise_c
);
    localparam int unsigned SYNC_W = 3;

    logic [SYNC_W-1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_W-2:0], req};
    end

    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    // Stage 2 is the last metastability-safe bit; stage 3 holds its previous value
    assign rise_c = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Moore phase sequencer for two roads plus a pedestrian crossing.
// TRAFFIC_WALK_FLASH_EN enables the flashing don't-walk interval.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_A_S = DEF_GREEN_A_S,
    parameter int unsigned GREEN_B_S = DEF_GREEN_B_S,
    parameter int unsigned YELLOW_S  = DEF_YELLOW_S,
    parameter int unsigned ALLRED_S  = DEF_ALLRED_S,
    parameter int unsigned WALK_S    = DEF_WALK_S,
    parameter int unsigned FLASH_S   = DEF_FLASH_S
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_phase_ctrl_if.slave  bus
);

    state_t             state_q, state_d;
    state_t             seq_next_c;
    logic [SEC_W-1:0]   sec_cnt_q, sec_cnt_d;
    logic [SEC_W-1:0]   last_sec_c;
    logic               walk_pending_q, walk_pending_d;
    logic [LAMP_W-1:0]  lamp_q, lamp_d;
    logic               walk_rise_c;
    logic               in_walk_c;
    logic               flash_c;

    walk_req_sync u_walk_req_sync (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.walk_req),
        .rise_c (walk_rise_c)
    );

    // Final second count of the current state
    always_comb begin
        last_sec_c = SEC_W'(ALLRED_S - 1);
        case (state_q)
            A_GREEN:    last_sec_c = SEC_W'(GREEN_A_S - 1);
            A_YELLOW:   last_sec_c = SEC_W'(YELLOW_S - 1);
            B_GREEN:    last_sec_c = SEC_W'(GREEN_B_S - 1);
            B_YELLOW:   last_sec_c = SEC_W'(YELLOW_S - 1);
            WALK:       last_sec_c = SEC_W'(WALK_S - 1);
`ifdef TRAFFIC_WALK_FLASH_EN
            WALK_FLASH: last_sec_c = SEC_W'(FLASH_S - 1);
`endif
            default:    last_sec_c = SEC_W'(ALLRED_S - 1);
        endcase
    end

    // Successor phase once the current one expires
    always_comb begin
        seq_next_c = ALL_RED_A;
        case (state_q)
            ALL_RED_A:  seq_next_c = A_GREEN;
            A_GREEN:    seq_next_c = A_YELLOW;
            A_YELLOW:   seq_next_c = ALL_RED_B;
            ALL_RED_B:  seq_next_c = B_GREEN;
            B_GREEN:    seq_next_c = B_YELLOW;
            B_YELLOW:   seq_next_c = walk_pending_q ? WALK : ALL_RED_A;
`ifdef TRAFFIC_WALK_FLASH_EN
            WALK:       seq_next_c = WALK_FLASH;
`endif
            default:    seq_next_c = ALL_RED_A;
        endcase
    end

`ifdef TRAFFIC_WALK_FLASH_EN
    logic flash_phase_q, flash_phase_d;

    assign in_walk_c = (state_q == WALK) || (state_q == WALK_FLASH);

    // Exit from WALK_FLASH wins over a coincident half-second toggle
    always_comb begin
        flash_phase_d = flash_phase_q;
        if (state_d == WALK_FLASH && state_q != WALK_FLASH)
            flash_phase_d = 1'b1;
        else if (state_q == WALK_FLASH && state_d == WALK_FLASH && bus.tick_2hz)
            flash_phase_d = ~flash_phase_q;
    end

    always_ff @(posedge clk) begin
        if (rst) flash_phase_q <= 1'b1;
        else     flash_phase_q <= flash_phase_d;
    end

    assign flash_c = flash_phase_d;
`else
    logic                  unused_tick_2hz;
    localparam int unsigned unused_flash_s = FLASH_S;

    assign unused_tick_2hz = bus.tick_2hz;
    assign in_walk_c       = (state_q == WALK);
    assign flash_c         = 1'b1;
`endif

    // Next state, second counter and walk request latch
    always_comb begin
        state_d        = state_q;
        sec_cnt_d      = sec_cnt_q;
        walk_pending_d = walk_pending_q;

        if (bus.tick_1hz) begin
            if (sec_cnt_q == last_sec_c) begin
                state_d   = seq_next_c;
                sec_cnt_d = '0;
            end else begin
                sec_cnt_d = sec_cnt_q + SEC_W'(1);
            end
        end

        if (walk_rise_c && !in_walk_c)
            walk_pending_d = 1'b1;
        if (state_d == WALK && state_q != WALK)
            walk_pending_d = 1'b0;
    end

    // Lamps are decoded from the next state so they register alongside it
    always_comb begin
        lamp_d          = '0;
        lamp_d[LAMP_RA] = 1'b1;
        lamp_d[LAMP_RB] = 1'b1;
        lamp_d[LAMP_RW] = 1'b1;
        case (state_d)
            A_GREEN:    begin lamp_d[LAMP_GA] = 1'b1; lamp_d[LAMP_RA] = 1'b0; end
            A_YELLOW:   begin lamp_d[LAMP_YA] = 1'b1; lamp_d[LAMP_RA] = 1'b0; end
            B_GREEN:    begin lamp_d[LAMP_GB] = 1'b1; lamp_d[LAMP_RB] = 1'b0; end
            B_YELLOW:   begin lamp_d[LAMP_YB] = 1'b1; lamp_d[LAMP_RB] = 1'b0; end
            WALK:       begin lamp_d[LAMP_GW] = 1'b1; lamp_d[LAMP_RW] = 1'b0; end
`ifdef TRAFFIC_WALK_FLASH_EN
            WALK_FLASH: lamp_d[LAMP_RW] = flash_c;
`endif
            default:    lamp_d[LAMP_RW] = flash_c | ~in_walk_c | 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ALL_RED_A;
            sec_cnt_q      <= '0;
            walk_pending_q <= 1'b0;
            lamp_q         <= LAMP_ALL_RED;
        end else begin
            state_q        <= state_d;
            sec_cnt_q      <= sec_cnt_d;
            walk_pending_q <= walk_pending_d;
            lamp_q         <= lamp_d;
        end
    end

    assign bus.Ga = lamp_q[LAMP_GA];
    assign bus.Ya = lamp_q[LAMP_YA];
    assign bus.Ra = lamp_q[LAMP_RA];
    assign bus.Gb = lamp_q[LAMP_GB];
    assign bus.Yb = lamp_q[LAMP_YB];
    assign bus.Rb = lamp_q[LAMP_RB];
    assign bus.Gw = lamp_q[LAMP_GW];
    assign bus.Rw = lamp_q[LAMP_RW];

endmodule
